// File: rtl/eco32_wb_pkg.sv
// eco32_wb_pkg: bus size encodings, bridge FSM states and byte-lane helpers
// for the eco32 to Wishbone B3 bridge.
package eco32_wb_pkg;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} bus_size_e;
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_RESP} wb_state_e;
  function automatic logic [3:0] lane_sel(input logic [1:0] size, input logic [1:0] a, input logic big_endian);
    logic [3:0] s;
    s = size == SZ_BYTE ? 4'b0001 << a : size == SZ_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    return big_endian ? {s[0], s[1], s[2], s[3]} : s;
  endfunction
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
    return size == SZ_BYTE ? {4{d[7:0]}} : size == SZ_HALF ? {2{d[15:0]}} : d;
  endfunction
  // The select already encodes endianness, so extraction only follows the lanes.
  function automatic logic [31:0] lane_rdata(input logic [3:0] sel, input logic [31:0] d);
    case (sel)
      4'b1000: return {4{d[31:24]}};
      4'b0100: return {4{d[23:16]}};
      4'b0010: return {4{d[15:8]}};
      4'b0001: return {4{d[7:0]}};
      4'b1100: return {2{d[31:16]}};
      4'b0011: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction
endpackage

// File: rtl/eco32_wb_wbuf.sv
// eco32_wb_wbuf: posted-write FIFO of DEPTH entries, W bits wide; pointers wrap
// modulo DEPTH, so non-power-of-two depths are fine.
module eco32_wb_wbuf #(
  parameter int DEPTH = 4,
  parameter int W = 68
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign head = mem[rd_ptr];
  always_ff @(posedge wb_clk_i)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/eco32_wb_bridge.sv
// eco32_wb_bridge: eco32 bus to Wishbone B3 classic master with posted writes.
// Define ECO32_WB_BRIDGE_TIMEOUT_EN to abort WB cycles after TIMEOUT_CYCLES.
module eco32_wb_bridge
  import eco32_wb_pkg::*;
#(
  parameter int AW = 32,
  parameter int WBUF_DEPTH = 4,
  parameter int BIG_ENDIAN = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          bus_en,
  input  logic          bus_wr,
  input  logic [1:0]    bus_size,
  input  logic [AW-1:0] bus_addr,
  input  logic [31:0]   bus_data_out,
  output logic [31:0]   bus_data_in,
  output logic          bus_wt,
  output logic          bus_err,
  output logic [AW-1:0] wb_adr_o,
  output logic [31:0]   wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic [31:0]   wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  output logic          wr_err_o
);
  localparam int EW = AW + 36;
  if (WBUF_DEPTH < 1 || WBUF_DEPTH > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("eco32_wb_bridge: parameter out of range");
  end
  wb_state_e state;
  logic full, empty, accept, pop, timeout, abort, done;
  logic [EW-1:0] head;
  logic [AW-1:0] head_adr;
  logic [3:0] head_sel;
  logic [31:0] head_dat;
  assign {head_adr, head_sel, head_dat} = head;
  assign accept = wb_rst_ni & bus_en & bus_wr & ~full;
  assign bus_wt = ~(accept | state == ST_RESP);
  assign abort = wb_err_i | (timeout & ~wb_ack_i);
  assign done = wb_ack_i | abort;
  assign pop = state == ST_WRITE & done;
  assign wb_cti_o = 3'b000;
  assign wb_bte_o = 2'b00;
  eco32_wb_wbuf #(.DEPTH(WBUF_DEPTH), .W(EW)) u_wbuf (
    .wb_clk_i (wb_clk_i),
    .wb_rst_ni(wb_rst_ni),
    .push     (accept),
    .pop      (pop),
    .din      ({bus_addr, lane_sel(bus_size, bus_addr[1:0], BIG_ENDIAN != 0), lane_wdata(bus_size, bus_data_out)}),
    .full     (full),
    .empty    (empty),
    .head     (head)
  );
`ifdef ECO32_WB_BRIDGE_TIMEOUT_EN
  logic [15:0] to_cnt;
  assign timeout = to_cnt == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge wb_clk_i)
    to_cnt <= (!wb_rst_ni || state == ST_IDLE) ? '0 : (state == ST_WRITE || state == ST_READ) ? to_cnt + 1'b1 : to_cnt;
`else
  assign timeout = 1'b0;
`endif
  // Buffered writes always drain before a read issues, keeping program order.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state <= ST_IDLE;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      bus_data_in <= '0;
      bus_err <= 1'b0;
      wr_err_o <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      wr_err_o <= 1'b0;
      case (state)
        ST_IDLE:
          if (!empty) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o <= 1'b1;
            wb_adr_o <= head_adr;
            wb_sel_o <= head_sel;
            wb_dat_o <= head_dat;
            state <= ST_WRITE;
          end else if (bus_en && !bus_wr) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o <= 1'b0;
            wb_adr_o <= bus_addr;
            wb_sel_o <= lane_sel(bus_size, bus_addr[1:0], BIG_ENDIAN != 0);
            state <= ST_READ;
          end
        ST_WRITE:
          if (done) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wr_err_o <= abort;
            state <= ST_IDLE;
          end
        ST_READ:
          if (done) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            bus_data_in <= abort ? '0 : lane_rdata(wb_sel_o, wb_dat_i);
            bus_err <= abort;
            state <= ST_RESP;
          end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
